// File: rtl/quad_count_ctrl.sv
// quad_count_ctrl
// Decodes a two-phase quadrature encoder into step commands for an external
// up/down counter. The controller drives the counter's direction, count
// enable and parallel-load pins, and keeps sticky fault flags.
//
// Parameters
//   DATA_WIDTH  width of the preset / parallel-data path
//   SYNC_STAGES synchronizer depth on A and B (>= 2)
//   FILTER_LEN  consecutive equal samples needed to accept a new phase state
//   WRAP_EN     1 = ignore TC, 0 = suppress same-direction steps while TC=1
//
// Ports
//   clk, MR_n         clock (rising edge), async active-low master reset
//   A, B              raw quadrature phases (asynchronous to clk)
//   LOAD_n, PRESET    synchronous preset request and its value
//   TC                terminal count returned by the counter
//   FLAG_CLR          synchronous clear of ERR/OVF/LOST
//   U_D, CE_n         direction (1 = up) and active-low count enable pulse
//   PE_n, P           active-low parallel-load enable and parallel data
//   ERR, OVF, LOST    sticky illegal-jump, suppressed-step, load-dropped flags
module quad_count_ctrl #(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 3,
  parameter int WRAP_EN     = 0
) (
  input  logic                  clk,
  input  logic                  MR_n,
  input  logic                  A,
  input  logic                  B,
  input  logic                  LOAD_n,
  input  logic [DATA_WIDTH-1:0] PRESET,
  input  logic                  TC,
  input  logic                  FLAG_CLR,
  output logic                  U_D,
  output logic                  CE_n,
  output logic                  PE_n,
  output logic [DATA_WIDTH-1:0] P,
  output logic                  ERR,
  output logic                  OVF,
  output logic                  LOST
);

  localparam int CNT_W = $clog2(FILTER_LEN + 1);

  typedef enum logic {INIT, TRACK} state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] a_sync, b_sync;
  logic [1:0]             sync_ab;
  logic [1:0]             acc_q, cand_q;
  logic [CNT_W-1:0]       cnt_q, cnt_next;
  logic                   differs, accept;

  logic step_evt, step_up, err_evt;
  logic step_pend_q, step_dir_q, err_pend_q;
  logic load_req, tc_block, step_go;
  logic err_set, ovf_set, lost_set;

  assign sync_ab = {a_sync[SYNC_STAGES-1], b_sync[SYNC_STAGES-1]};

  // Metastability guard: both phases shift through their own flop chain and
  // nothing downstream looks at A or B directly.
  always_ff @(posedge clk or negedge MR_n) begin
    if (!MR_n) begin
      a_sync <= '0;
      b_sync <= '0;
    end else begin
      a_sync <= {a_sync[SYNC_STAGES-2:0], A};
      b_sync <= {b_sync[SYNC_STAGES-2:0], B};
    end
  end

  // Glitch filter: count consecutive identical samples that differ from the
  // accepted state. In INIT the comparison against the accepted state is
  // bypassed so the very first stable value gets adopted even if it happens
  // to equal the cleared accepted state.
  always_comb begin
    differs  = (state_q == INIT) || (sync_ab != acc_q);
    cnt_next = CNT_W'(1);
    if (cnt_q != '0 && sync_ab == cand_q) begin
      cnt_next = cnt_q + CNT_W'(1);
    end
    accept = differs && (cnt_next == CNT_W'(FILTER_LEN));
  end

  // Filter state: a sample that matches the accepted state, or a change of
  // candidate, restarts the count so short pulses never accumulate.
  always_ff @(posedge clk or negedge MR_n) begin
    if (!MR_n) begin
      acc_q  <= '0;
      cand_q <= '0;
      cnt_q  <= '0;
    end else if (!differs) begin
      cnt_q <= '0;
    end else if (accept) begin
      acc_q <= sync_ab;
      cnt_q <= '0;
    end else begin
      cand_q <= sync_ab;
      cnt_q  <= cnt_next;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge MR_n) begin
    if (!MR_n) begin
      state_q <= INIT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and transition decode. The phase sequence 00,01,11,10 is a
  // Gray code, so a single-bit change is a step whose direction follows the
  // sequence and a two-bit change is an illegal jump.
  always_comb begin
    state_d  = state_q;
    step_evt = 1'b0;
    step_up  = 1'b0;
    err_evt  = 1'b0;
    if (accept) begin
      case (state_q)
        INIT: state_d = TRACK;
        TRACK: begin
          case ({acc_q, sync_ab})
            4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: begin
              step_evt = 1'b1;
              step_up  = 1'b1;
            end
            4'b01_00, 4'b11_01, 4'b10_11, 4'b00_10: begin
              step_evt = 1'b1;
            end
            default: err_evt = 1'b1;
          endcase
        end
        default: state_d = INIT;
      endcase
    end
  end

  // Hold the decoded event for one cycle so the counter sees it in the cycle
  // after acceptance, lined up with the load/TC arbitration below.
  always_ff @(posedge clk or negedge MR_n) begin
    if (!MR_n) begin
      step_pend_q <= 1'b0;
      step_dir_q  <= 1'b1;
      err_pend_q  <= 1'b0;
    end else begin
      step_pend_q <= step_evt;
      step_dir_q  <= step_up;
      err_pend_q  <= err_evt;
    end
  end

  // Arbitration: a load wins over a step (step lost), otherwise a step into
  // the terminal count in the same direction is suppressed unless wrapping
  // is allowed.
  always_comb begin
    load_req = !LOAD_n;
    tc_block = (WRAP_EN == 0) && TC && (step_dir_q == U_D);
    step_go  = step_pend_q && !load_req && !tc_block;
    lost_set = step_pend_q && load_req;
    ovf_set  = step_pend_q && !load_req && tc_block;
    err_set  = err_pend_q;
  end

  // Registered counter-side outputs. Every output comes straight from a flop
  // so reset forces them cleanly and an aborted step cannot glitch CE_n.
  always_ff @(posedge clk or negedge MR_n) begin
    if (!MR_n) begin
      U_D  <= 1'b1;
      CE_n <= 1'b1;
      PE_n <= 1'b1;
      P    <= '0;
    end else begin
      CE_n <= !step_go;
      PE_n <= !load_req;
      if (load_req) begin
        P <= PRESET;
      end
      if (step_pend_q && !load_req) begin
        U_D <= step_dir_q;
      end
    end
  end

  // Sticky flags: a setting event in the same cycle as FLAG_CLR wins.
  always_ff @(posedge clk or negedge MR_n) begin
    if (!MR_n) begin
      ERR  <= 1'b0;
      OVF  <= 1'b0;
      LOST <= 1'b0;
    end else begin
      if (err_set)       ERR <= 1'b1;
      else if (FLAG_CLR) ERR <= 1'b0;
      if (ovf_set)       OVF <= 1'b1;
      else if (FLAG_CLR) OVF <= 1'b0;
      if (lost_set)       LOST <= 1'b1;
      else if (FLAG_CLR)  LOST <= 1'b0;
    end
  end

endmodule

// File: tb/tb_quad_count_ctrl.sv
// tb_quad_count_ctrl
// Directed plus randomized bench for quad_count_ctrl with default parameters.
// The reference model tracks the encoder as a position 0..3 and derives each
// step as (new - old) mod 4: 1 = up, 3 = down, 2 = illegal jump. Expected
// outputs appear SYNC_STAGES+FILTER_LEN edges after a level change.
module tb_quad_count_ctrl;

  logic       clk = 1'b0;
  logic       MR_n, A, B, LOAD_n, TC, FLAG_CLR;
  logic [7:0] PRESET;
  logic       U_D, CE_n, PE_n, ERR, OVF, LOST;
  logic [7:0] P;

  int total = 0;
  int bad   = 0;

  // reference model state
  int         pos;
  logic       expCe, expPe, expUd, expErr, expOvf, expLost;
  logic [7:0] expP;

  localparam int LAT = 6;  // ticks after a change at which the pulse shows

  quad_count_ctrl dut (
    .clk(clk), .MR_n(MR_n), .A(A), .B(B), .LOAD_n(LOAD_n), .PRESET(PRESET),
    .TC(TC), .FLAG_CLR(FLAG_CLR), .U_D(U_D), .CE_n(CE_n), .PE_n(PE_n),
    .P(P), .ERR(ERR), .OVF(OVF), .LOST(LOST)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] gray(input int p);
    return 2'(p ^ (p >> 1));
  endfunction

  task automatic checkOutput(input string tag, input logic obs, input logic expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, expv);
    end
  endtask

  task automatic checkOutputByte(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, ".CE_n"}, CE_n, expCe);
    checkOutput({tag, ".PE_n"}, PE_n, expPe);
    checkOutputByte({tag, ".P"}, P, expP);
    checkOutput({tag, ".U_D"}, U_D, expUd);
    checkOutput({tag, ".ERR"}, ERR, expErr);
    checkOutput({tag, ".OVF"}, OVF, expOvf);
    checkOutput({tag, ".LOST"}, LOST, expLost);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One encoder move of 'delta' positions, held for 'hold' cycles, with an
  // optional load request sampled at edge 'loadTick' (0 = none).
  task automatic applyStimulus(input string tag, input int delta, input int hold,
                               input int loadTick, input logic tcLvl,
                               input logic [7:0] preset);
    logic dirUp;
    logic isStep;
    dirUp  = (delta == 1);
    isStep = (delta != 2);
    pos    = (pos + delta) % 4;
    {A, B} = gray(pos);
    TC     = tcLvl;
    PRESET = preset;
    for (int t = 1; t <= hold; t++) begin
      LOAD_n = (t == loadTick) ? 1'b0 : 1'b1;
      tick();
      expCe = 1'b1;
      expPe = 1'b1;
      if (t == loadTick) begin
        expPe = 1'b0;
        expP  = preset;
      end
      if (t == LAT) begin
        if (!isStep)                      expErr  = 1'b1;
        else if (t == loadTick)           expLost = 1'b1;
        else if (tcLvl && dirUp == expUd) expOvf  = 1'b1;
        else begin
          expCe = 1'b0;
          expUd = dirUp;
        end
      end
      checkAll($sformatf("%s.t%0d", tag, t));
    end
    LOAD_n = 1'b1;
  endtask

  task automatic clearFlags(input string tag);
    FLAG_CLR = 1'b1;
    tick();
    FLAG_CLR = 1'b0;
    expErr  = 1'b0;
    expOvf  = 1'b0;
    expLost = 1'b0;
    expCe   = 1'b1;
    expPe   = 1'b1;
    checkAll(tag);
  endtask

  initial begin
    int r, delta, hold, ldt;

    // reset values while MR_n is low, with both phases high
    MR_n = 1'b0; A = 1'b1; B = 1'b1; LOAD_n = 1'b1; TC = 1'b0;
    FLAG_CLR = 1'b0; PRESET = 8'h00;
    expCe = 1'b1; expPe = 1'b1; expP = 8'h00; expUd = 1'b1;
    expErr = 1'b0; expOvf = 1'b0; expLost = 1'b0;
    repeat (3) tick();
    checkAll("reset");

    // INIT adoption of 11: no pulse, no error
    MR_n = 1'b1;
    pos  = 2;
    for (int i = 0; i < 20; i++) begin
      tick();
      checkAll($sformatf("init%0d", i));
    end

    // walk to 00, then the forward sequence 00,01,11,10,00
    applyStimulus("pre1", 1, 10, 0, 1'b0, 8'h00);
    applyStimulus("pre2", 1, 10, 0, 1'b0, 8'h00);
    for (int i = 0; i < 4; i++) begin
      applyStimulus($sformatf("fwd%0d", i), 1, 10, 0, 1'b0, 8'h00);
    end

    // 2-cycle glitch on A: ignored, accepted state unchanged
    A = ~A;
    for (int t = 1; t <= 12; t++) begin
      if (t == 3) A = ~A;
      tick();
      checkAll($sformatf("glitch.t%0d", t));
    end
    applyStimulus("postglitch", 1, 10, 0, 1'b0, 8'h00);

    // illegal jump, then clear
    applyStimulus("jump", 2, 10, 0, 1'b0, 8'h00);
    clearFlags("errclr");

    // TC with U_D=1: up suppressed, down passes
    applyStimulus("tcup", 1, 10, 0, 1'b1, 8'h00);
    applyStimulus("tcdn", 3, 10, 0, 1'b1, 8'h00);
    clearFlags("ovfclr");

    // load coinciding with an accepted step
    applyStimulus("load", 1, 10, LAT, 1'b0, 8'hA5);
    clearFlags("lostclr");

    // randomized walk
    for (int s = 0; s < 30; s++) begin
      r     = int'($urandom_range(0, 9));
      delta = (r < 2) ? 2 : ((r % 2 == 1) ? 1 : 3);
      hold  = int'($urandom_range(7, 12));
      ldt   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, hold)) : 0;
      applyStimulus($sformatf("rnd%0d", s), delta, hold, ldt,
                    logic'($urandom_range(0, 1)), 8'($urandom));
      if ($urandom_range(0, 1) == 1) clearFlags($sformatf("rndclr%0d", s));
    end

    // reset asserted while a step is in flight: outputs go to reset values
    TC = 1'b0;
    pos = (pos + 1) % 4;
    {A, B} = gray(pos);
    repeat (5) tick();
    #2;
    MR_n = 1'b0;
    #1;
    expCe = 1'b1; expPe = 1'b1; expP = 8'h00; expUd = 1'b1;
    expErr = 1'b0; expOvf = 1'b0; expLost = 1'b0;
    checkAll("midrst");
    tick();
    checkAll("midrst.after");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/quad_count_ctrl.md
QUAD_COUNT_CTRL -- requirements
Module: quad_count_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 8: width of the preset value driven to the counter's parallel-data input.
REQ-002 Parameter SYNC_STAGES, default 2, minimum 2: number of synchronizer flops on each phase input.
REQ-003 Parameter FILTER_LEN, default 3, minimum 1: number of consecutive equal synchronized samples required to accept a new phase state.
REQ-004 Parameter WRAP_EN, default 0: 1 = allow counter wrap at terminal count; 0 = suppress the step and flag overflow.
REQ-005 Port clk, input, 1: system clock; all logic on its rising edge.
REQ-006 Port MR_n, input, 1: reset, asynchronous and active-low.
REQ-007 Port A, input, 1: quadrature phase A, asynchronous to clk.
REQ-008 Port B, input, 1: quadrature phase B, asynchronous to clk.
REQ-009 Port LOAD_n, input, 1: synchronous preset request when low.
REQ-010 Port PRESET, input, DATA_WIDTH: value to load into the counter.
REQ-011 Port TC, input, 1: terminal-count flag returned from the driven counter.
REQ-012 Port FLAG_CLR, input, 1: synchronous clear of the sticky flags when high.
REQ-013 Port U_D, output, 1: count direction to the counter; 1 = up, 0 = down.
REQ-014 Port CE_n, output, 1: count enable to the counter, active-low, one-cycle pulse per accepted step.
REQ-015 Port PE_n, output, 1: parallel-load enable to the counter, active-low.
REQ-016 Port P, output, DATA_WIDTH: parallel data to the counter.
REQ-017 Port ERR, output, 1: sticky illegal-transition flag.
REQ-018 Port OVF, output, 1: sticky suppressed-at-terminal-count flag.
REQ-019 Port LOST, output, 1: sticky step-dropped-by-load flag.

Function
REQ-020 A and B SHALL each pass through a SYNC_STAGES-deep flop chain before any other use.
REQ-021 Filter: the accepted state {A,B} SHALL update only when the synchronized value has differed from it and remained identical for FILTER_LEN consecutive samples; a shorter pulse SHALL be ignored and SHALL restart the filter count.
REQ-022 FSM states: INIT and TRACK; reset enters INIT.
REQ-023 In INIT, the first filtered value SHALL be adopted as the accepted state without generating a step; the FSM then moves to TRACK.
REQ-024 In TRACK, the sequences 00->01, 01->11, 11->10 and 10->00 SHALL be up steps, and the reverse transitions SHALL be down steps.
REQ-025 A change of both bits in one acceptance SHALL set ERR, adopt the new state, and generate no step.
REQ-026 Step output: in the cycle after acceptance, CE_n SHALL be low for exactly one cycle and U_D SHALL be registered with the step direction in that same cycle; U_D SHALL hold between steps.
REQ-027 Latency: a level change stable from sampling edge k SHALL produce CE_n low during the clock period following edge k+SYNC_STAGES+FILTER_LEN (edge k+5 with defaults).
REQ-028 With WRAP_EN=0, a step SHALL be suppressed (CE_n stays high) and OVF set when TC=1 and the step direction equals the current U_D; U_D SHALL still update.
REQ-029 With WRAP_EN=1, TC SHALL be ignored.
REQ-030 LOAD_n low at an edge SHALL drive PE_n low and P=PRESET for the following cycle, with CE_n high in that cycle.
REQ-031 A step generated in the same cycle as a load SHALL be dropped and SHALL set LOST; load takes priority.
REQ-032 FLAG_CLR SHALL clear ERR, OVF and LOST, except that a flag-setting event in the same cycle SHALL win and the flag SHALL remain set.
REQ-033 P SHALL hold its last loaded value when PE_n is high.

Reset
REQ-034 While MR_n=0, all outputs SHALL be held at their reset values: U_D=1, CE_n=1, PE_n=1, P=0, ERR=0, OVF=0, LOST=0.
REQ-035 While MR_n=0, the synchronizers, filter and accepted state SHALL be held cleared and the FSM in INIT.
REQ-036 Assertion of MR_n mid-step SHALL abort any pending CE_n pulse with no glitch.

Verification
REQ-037 Reset release with A=1, B=1, held 20 cycles -> no CE_n pulse, ERR=0 (INIT adoption).
REQ-038 Forward sequence 00,01,11,10,00, each level held 10 cycles -> four CE_n pulses, each 1 cycle long, U_D=1, first pulse at sample edge +5.
REQ-039 2-cycle glitch on A with FILTER_LEN=3 -> no CE_n pulse, accepted state unchanged.
REQ-040 Jump 00->11 -> ERR=1, no CE_n; then FLAG_CLR=1 for one cycle -> ERR=0.
REQ-041 WRAP_EN=0, TC=1, U_D=1, up step -> CE_n stays 1, OVF=1; down step -> CE_n pulses, U_D=0.
REQ-042 LOAD_n=0 with PRESET=0xA5 coinciding with an accepted step -> PE_n=0 and P=0xA5 for one cycle, CE_n=1, LOST=1.
